// File: rtl/hello_pkg.sv
// Purpose : shared constants and helpers for the hello_led smoke-test block.
// Contents: default divider width, edge-counter width, half_period() helper.
// Macro   : HELLO_EDGE_COUNT_EN (consumed by hello_led_top) enables blink_edges.
package hello_pkg;

  localparam int DEFAULT_DIV_BIT = 26;
  localparam int EDGE_CNT_W      = 16;

  // Number of clk cycles between consecutive led_blink toggles.
  function automatic longint unsigned half_period(input int unsigned div_bit);
    return 64'd1 << (div_bit - 1);
  endfunction

endpackage

// File: rtl/hello_clk_div.sv
// Purpose : free-running WIDTH-bit binary divider with registered MSB output.
// Ports   : clk, rst_n (sync, active-low) in; blink (registered MSB) and
//           blink_tgl (blink changes on the coming edge) out.
module hello_clk_div #(
  parameter int WIDTH = 26
) (
  input  logic clk,
  input  logic rst_n,
  output logic blink,
  output logic blink_tgl
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("hello_clk_div: WIDTH must be within 2..32");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q + WIDTH'(1);
    // Tracking the MSB of the next count keeps blink cycle-aligned with cnt:
    // after N enabled edges blink equals bit WIDTH-1 of N.
    blink_d = cnt_d[WIDTH-1];
    if (!rst_n) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    blink_q <= blink_d;
  end

  assign blink     = blink_q;
  // Lookahead so a downstream counter can update on the same edge as blink.
  assign blink_tgl = blink_d ^ blink_q;

endmodule

// File: rtl/hello_led_top.sv
// Purpose : board bring-up LEDs: constant-on power LED and divided blink LED.
// Ports   : clk, rst_n (sync, active-low) in; led_on, led_blink out;
//           blink_edges[15:0] out only when HELLO_EDGE_COUNT_EN is defined.
module hello_led_top
  import hello_pkg::*;
#(
  parameter int DIV_BIT = DEFAULT_DIV_BIT
) (
  input  logic clk,
  input  logic rst_n,
  output logic led_on,
  output logic led_blink
`ifdef HELLO_EDGE_COUNT_EN
  ,
  output logic [EDGE_CNT_W-1:0] blink_edges
`endif
);

  logic blink_tgl;

  assign led_on = 1'b1;

  hello_clk_div #(
    .WIDTH (DIV_BIT)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .blink     (led_blink),
    .blink_tgl (blink_tgl)
  );

`ifdef HELLO_EDGE_COUNT_EN
  logic [EDGE_CNT_W-1:0] edges_q, edges_d;

  always_comb begin
    edges_d = edges_q;
    // Saturating count of blink toggles; holds at all-ones.
    if (blink_tgl && (edges_q != '1)) begin
      edges_d = edges_q + EDGE_CNT_W'(1);
    end
    if (!rst_n) begin
      edges_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    edges_q <= edges_d;
  end

  assign blink_edges = edges_q;
`else
  logic unused_blink_tgl;
  assign unused_blink_tgl = blink_tgl;
`endif

endmodule

// File: tb/tb_hello_led_top.sv
module tb_hello_led_top;
  import hello_pkg::*;

  localparam int              DIV_BIT = 4;
  localparam longint unsigned HALF    = half_period(DIV_BIT);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic led_on;
  logic led_blink;
`ifdef HELLO_EDGE_COUNT_EN
  logic [EDGE_CNT_W-1:0] blink_edges;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: enabled posedges since the last reset edge.
  longint unsigned n_run   = 0;
  longint unsigned last_ev = 0;
  logic            prev_blink = 1'b0;

  always #5 clk = ~clk;

  hello_led_top #(
    .DIV_BIT (DIV_BIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led_on    (led_on),
    .led_blink (led_blink)
`ifdef HELLO_EDGE_COUNT_EN
    ,
    .blink_edges (blink_edges)
`endif
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (run=%0d)", tag, obs, exp, n_run);
    end
  endtask

  task automatic check_num(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (run=%0d)", tag, obs, exp, n_run);
    end
  endtask

  // One clock: drive rst_n, sample 1 ns after the edge, compare to the model.
  task automatic step(input logic rst_val);
    longint unsigned toggles;
    rst_n = rst_val;
    @(posedge clk);
    #1;
    if (!rst_val) begin
      n_run   = 0;
      last_ev = 0;
    end else begin
      n_run++;
    end
    toggles = n_run / HALF;
    check_bit("led_on", led_on, 1'b1);
    check_bit("led_blink", led_blink, logic'(toggles % 2));
`ifdef HELLO_EDGE_COUNT_EN
    check_num("blink_edges", longint'(blink_edges), (toggles > 65535) ? 65535 : toggles);
`endif
    // Independent spacing check: each toggle is HALF cycles after release
    // or after the previous toggle.
    if (rst_val && (led_blink !== prev_blink)) begin
      check_num("edge_spacing", n_run - last_ev, HALF);
      last_ev = n_run;
    end
    prev_blink = led_blink;
  endtask

  initial begin
    int run_len;
    int rst_len;

    // Reset held 100 cycles: outputs known and quiet throughout.
    for (int i = 0; i < 100; i++) step(1'b0);

    // Release: first rise at HALF, then 8+ edges including the 15->0 wrap.
    for (int i = 0; i < 70; i++) step(1'b1);

    // Reset mid high phase (cycle 11 after release), then restart.
    step(1'b0);
    for (int i = 0; i < 11; i++) step(1'b1);
    check_bit("blink_high_before_reset", led_blink, 1'b1);
    step(1'b0);
    check_bit("blink_cleared_by_reset", led_blink, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);

    // Randomized run lengths and reset pulses against the model.
    for (int k = 0; k < 30; k++) begin
      run_len = $urandom_range(1, 80);
      rst_len = $urandom_range(1, 3);
      for (int i = 0; i < run_len; i++) step(1'b1);
      for (int i = 0; i < rst_len; i++) step(1'b0);
    end
    for (int i = 0; i < 40; i++) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
